// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and helpers for the RV32M multiply/divide unit
package muldiv_pkg;

   // Default operand width of the unit
   localparam int DEF_WIDTH = 32;

   // RV32M funct3 encodings
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Width of an iteration counter that runs 0 .. w-1
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/muldiv_core_step.sv
// rtl/muldiv_core_step.sv - one combinational shift-add or restoring-divide iteration
module muldiv_core_step #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                      is_div_i,
   input  logic [2*DATA_WIDTH-1:0]   acc_i,
   input  logic [DATA_WIDTH-1:0]     b_i,
   output logic [2*DATA_WIDTH-1:0]   acc_o
);
   localparam int W = DATA_WIDTH;

   logic [W:0] sum;
   logic [W:0] rem_sh;
   logic [W:0] diff;

   // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}
   always_comb begin
      sum    = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, b_i} : '0);
      rem_sh = {acc_i[2*W-1:W], acc_i[W-1]};
      diff   = rem_sh - {1'b0, b_i};
      acc_o  = '0;
      if (!is_div_i) begin
         acc_o = {sum, acc_i[W-1:1]};
      end else if (rem_sh >= {1'b0, b_i}) begin
         acc_o = {diff[W-1:0], acc_i[W-2:0], 1'b1};
      end else begin
         acc_o = {rem_sh[W-1:0], acc_i[W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M multiply/divide unit with start/busy/done handshake
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_WIDTH,
   parameter int FUNCT_LENGTH = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [FUNCT_LENGTH-1:0] funct3,
   input  logic [DATA_WIDTH-1:0]   SrcA,
   input  logic [DATA_WIDTH-1:0]   SrcB,
   output logic                    busy,
   output logic                    done,
   output logic [DATA_WIDTH-1:0]   Result
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = cnt_width(W);
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   state_t                  state_q;
   logic [CW-1:0]           cnt_q;
   logic [2*W-1:0]          acc_q;
   logic [2*W-1:0]          acc_d;
   logic [W-1:0]            a_q;
   logic [W-1:0]            b_q;
   logic [W-1:0]            bmag_q;
   logic [FUNCT_LENGTH-1:0] op_q;
   logic                    a_neg_q;
   logic                    b_neg_q;
   logic [W-1:0]            Result_q;
   logic                    busy_q;
   logic                    done_q;

   logic                    sgn_a, sgn_b, a_neg_d, b_neg_d;
   logic [W-1:0]            a_mag_d, b_mag_d;
   logic [2*W-1:0]          prod;
   logic [W-1:0]            quo, rem;
   logic                    ovf;
   logic [W-1:0]            Result_d;

   muldiv_core_step #(.DATA_WIDTH(W)) u_step (
      .is_div_i (op_q[2]),
      .acc_i    (acc_q),
      .b_i      (bmag_q),
      .acc_o    (acc_d)
   );

   // Operand signedness and magnitudes for a request being accepted
   always_comb begin
      sgn_a   = !(funct3 == F3_MULHU || funct3 == F3_DIVU || funct3 == F3_REMU);
      sgn_b   = sgn_a && (funct3 != F3_MULHSU);
      a_neg_d = sgn_a && SrcA[W-1];
      b_neg_d = sgn_b && SrcB[W-1];
      a_mag_d = a_neg_d ? -SrcA : SrcA;
      b_mag_d = b_neg_d ? -SrcB : SrcB;
   end

   // Sign correction, special-case override and output selection applied in FIX
   always_comb begin
      prod = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
      quo  = acc_q[W-1:0];
      rem  = acc_q[2*W-1:W];
      if (a_neg_q ^ b_neg_q) quo = -quo;
      if (a_neg_q)           rem = -rem;
      ovf = (op_q == F3_DIV || op_q == F3_REM) && (a_q == MOST_NEG) && (b_q == '1);
      if (b_q == '0) begin
         quo = '1;
         rem = a_q;
      end else if (ovf) begin
         quo = MOST_NEG;
         rem = '0;
      end
      if (op_q[2])                    Result_d = op_q[1] ? rem : quo;
      else if (op_q[1:0] == 2'b00)    Result_d = prod[W-1:0];
      else                            Result_d = prod[2*W-1:W];
   end

   // Control FSM with registered busy/done/Result
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         bmag_q   <= '0;
         op_q     <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         Result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_q    <= funct3;
                  a_q     <= SrcA;
                  b_q     <= SrcB;
                  a_neg_q <= a_neg_d;
                  b_neg_q <= b_neg_d;
                  bmag_q  <= b_mag_d;
                  acc_q   <= {{W{1'b0}}, a_mag_d};
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= CALC;
               end
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(W - 1)) state_q <= FIX;
            end
            FIX: begin
               Result_q <= Result_d;
               busy_q   <= 1'b0;
               state_q  <= DONE;
            end
            DONE: begin
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign Result = Result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        busy;
   logic        done;
   logic [31:0] Result;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   muldiv_unit dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .funct3 (funct3),
      .SrcA   (SrcA),
      .SrcB   (SrcB),
      .busy   (busy),
      .done   (done),
      .Result (Result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Architectural RV32M result computed with 64-bit integer arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      p  = '0;
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Issue one request; optionally pulse start with junk operands at cycle glitch_k after acceptance
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int glitch_k, output logic [31:0] res, output int lat, output int bcnt);
      res  = '0;
      lat  = -1;
      bcnt = 0;
      @(negedge clk);
      funct3 = f3; SrcA = a; SrcB = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; funct3 = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
      for (int k = 0; k <= 60; k++) begin
         if (k > 0) @(negedge clk);
         start = (k == glitch_k);
         if (start) begin funct3 = 3'($urandom); SrcA = $urandom; SrcB = $urandom; end
         if (done) begin
            lat = k;
            res = Result;
            break;
         end
         if (busy) bcnt++;
      end
      start = 1'b0;
   endtask

   task automatic run_checked(input string name, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp, input int glitch_k);
      logic [31:0] res;
      int lat, bcnt;
      do_op(f3, a, b, glitch_k, res, lat, bcnt);
      check({name, " result"}, res, exp);
      check({name, " latency"}, 32'(lat), 32'd34);
      check({name, " busy_cycles"}, 32'(bcnt), 32'd33);
      @(negedge clk);
      check({name, " done_one_cycle"}, {31'b0, done}, 32'd0);
      check({name, " busy_after"}, {31'b0, busy}, 32'd0);
   endtask

   vec_t vecs[$];

   initial begin
      logic [2:0]  rf3;
      logic [31:0] ra, rb, hold;
      int          seen;

      vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
      vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
      vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
      vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF});
      vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
      vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
      vecs.push_back('{3'd5, 32'd100,        32'd7,         32'd14});
      vecs.push_back('{3'd7, 32'd100,        32'd7,         32'd2});
      vecs.push_back('{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF});
      vecs.push_back('{3'd6, 32'd5,          32'd0,         32'd5});
      vecs.push_back('{3'd5, 32'hFFFF_FFFF,  32'd0,         32'hFFFF_FFFF});
      vecs.push_back('{3'd7, 32'd7,          32'd0,         32'd7});
      vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
      vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0});
      vecs.push_back('{3'd0, 32'h1234_5678,  32'd0,         32'd0});
      vecs.push_back('{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0});
      vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3});
      vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF});
      vecs.push_back('{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1});

      reset = 1'b1; start = 1'b0; funct3 = '0; SrcA = '0; SrcB = '0;
      repeat (3) @(negedge clk);
      check("reset busy",   {31'b0, busy}, 32'd0);
      check("reset done",   {31'b0, done}, 32'd0);
      check("reset Result", Result,        32'd0);
      reset = 1'b0;

      foreach (vecs[i])
         run_checked($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, -1);

      // start re-asserted mid-multiply and during the DONE cycle must both be ignored
      run_checked("mul_restart_c10", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 10);
      run_checked("mul_restart_done", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      hold = Result;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("result_hold", Result, 32'hFFFF_FFEB);
      end

      // reset in the middle of a divide aborts it
      @(negedge clk);
      funct3 = 3'd4; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort busy",   {31'b0, busy}, 32'd0);
      check("abort done",   {31'b0, done}, 32'd0);
      check("abort Result", Result,        32'd0);
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("abort no_done", 32'(seen), 32'd0);
      run_checked("div_after_abort", 3'd4, 32'd9, 32'd3, 32'd3, -1);

      // randomized requests against the reference model
      for (int i = 0; i < 60; i++) begin
         rf3 = 3'($urandom_range(0, 7));
         ra  = pick_operand();
         rb  = pick_operand();
         run_checked($sformatf("rand%0d f3=%0d a=%08h b=%08h", i, rf3, ra, rb),
                     rf3, ra, rb, ref_model(rf3, ra, rb), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
